// File: rtl/sc_s2b_counter.sv
// Stochastic-to-binary converter: counts ones per lane over 2^k valid samples, then scales to WIDTH bits.
// done (and fresh Bzs/k_out) follows the edge that accepts the 2^k-th sample; no backpressure, valid_in qualifies samples.
module sc_s2b_counter #(
    parameter  int WIDTH      = 8,
    parameter  int NUM_INPUTS = 8,
    localparam int ET_W       = $clog2(WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ET_W-1:0]       et_log2,
    input  logic                  valid_in,
    input  logic [NUM_INPUTS-1:0] Xs,
    output logic                  busy,
    output logic                  done,
    output logic [ET_W-1:0]       k_out,
    output logic [WIDTH-1:0]      Bzs [NUM_INPUTS]
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    typedef logic [WIDTH:0] cnt_t;

    state_t           state_q, state_d;
    logic [ET_W-1:0]  k_q, k_d;
    logic [ET_W-1:0]  kout_q, kout_d;
    cnt_t             smp_q, smp_d;
    cnt_t             cnt_q [NUM_INPUTS];
    cnt_t             cnt_d [NUM_INPUTS];
    logic [WIDTH-1:0] bzs_q [NUM_INPUTS];
    logic [WIDTH-1:0] bzs_d [NUM_INPUTS];

    // A count of 2^k shifted up by WIDTH-k lands on 2^WIDTH, which must clip to all-ones.
    function automatic logic [WIDTH-1:0] scale_sat(input cnt_t c, input logic [ET_W-1:0] k);
        cnt_t s;
        s = c << (ET_W'(WIDTH) - k);
        return s[WIDTH] ? '1 : s[WIDTH-1:0];
    endfunction

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        kout_d  = kout_q;
        smp_d   = smp_q;
        cnt_d   = cnt_q;
        bzs_d   = bzs_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (et_log2 == '0)
                        k_d = ET_W'(1);
                    else if (et_log2 > ET_W'(WIDTH))
                        k_d = ET_W'(WIDTH);
                    else
                        k_d = et_log2;
                    smp_d = '0;
                    for (int i = 0; i < NUM_INPUTS; i++) cnt_d[i] = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (valid_in) begin
                    smp_d = smp_q + cnt_t'(1);
                    for (int i = 0; i < NUM_INPUTS; i++) cnt_d[i] = cnt_q[i] + cnt_t'(Xs[i]);
                    if (smp_d == (cnt_t'(1) << k_q)) begin
                        kout_d = k_q;
                        for (int i = 0; i < NUM_INPUTS; i++) bzs_d[i] = scale_sat(cnt_d[i], k_q);
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            kout_q  <= '0;
            smp_q   <= '0;
            for (int i = 0; i < NUM_INPUTS; i++) begin
                cnt_q[i] <= '0;
                bzs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            kout_q  <= kout_d;
            smp_q   <= smp_d;
            cnt_q   <= cnt_d;
            bzs_q   <= bzs_d;
        end
    end

    assign busy  = (state_q != S_IDLE);
    assign done  = (state_q == S_DONE);
    assign k_out = kout_q;
    assign Bzs   = bzs_q;

endmodule

// File: tb/tb_sc_s2b_counter.sv
// Bench for sc_s2b_counter: directed conversions with expected results queued at start, checked by a done monitor.
module tb_sc_s2b_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] et_log2;
    logic       valid_in;
    logic [7:0] Xs;
    logic       busy;
    logic       done;
    logic [3:0] k_out;
    logic [7:0] Bzs [8];

    always #5 clk = ~clk;

    sc_s2b_counter #(.WIDTH(8), .NUM_INPUTS(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .et_log2  (et_log2),
        .valid_in (valid_in),
        .Xs       (Xs),
        .busy     (busy),
        .done     (done),
        .k_out    (k_out),
        .Bzs      (Bzs)
    );

    typedef struct {
        logic [63:0] bzs;
        int          k;
        int          cyc;
    } exp_t;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    exp_t        sb [$];
    logic [7:0]  xs_vec [$];
    logic [63:0] last_bzs = '0;
    exp_t        e_mon;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] pack_bzs();
        logic [63:0] p;
        for (int i = 0; i < 8; i++) p[i*8 +: 8] = Bzs[i];
        return p;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Monitor: pops an expectation on every done pulse; otherwise results must hold.
    always @(negedge clk) begin
        if (!rst_n) last_bzs = '0;
        if (done) begin
            if (sb.size() == 0) begin
                chk("done_without_expectation", done, 1'b0);
            end else begin
                e_mon = sb.pop_front();
                chk("done_cycle", cyc, e_mon.cyc);
                chk("k_out", k_out, e_mon.k);
                chk("busy_in_done", busy, 1'b1);
                for (int i = 0; i < 8; i++)
                    chk($sformatf("bzs_lane%0d", i), Bzs[i], e_mon.bzs[i*8 +: 8]);
                last_bzs = e_mon.bzs;
            end
        end else begin
            chk("bzs_hold", pack_bzs(), last_bzs);
        end
    end

    // Runs one conversion over xs_vec; gap invalid cycles (Xs all ones) precede each valid sample.
    task automatic convert(input logic [3:0] et, input int keff, input int gap,
                           input bit mid_start, input bit done_start, input logic [63:0] exp_bzs);
        int   n;
        exp_t e;
        n     = xs_vec.size();
        e.bzs = exp_bzs;
        e.k   = keff;
        e.cyc = cyc + n * (gap + 1) + 1;
        sb.push_back(e);
        start = 1'b1; et_log2 = et; valid_in = 1'b1; Xs = 8'hFF;
        tick();
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap; g++) begin
                valid_in = 1'b0; Xs = 8'hFF;
                tick();
            end
            valid_in = 1'b1;
            Xs       = xs_vec[i];
            start    = mid_start && (i == 2);
            et_log2  = (mid_start && (i == 2)) ? 4'd2 : et;
            tick();
        end
        valid_in = 1'b0; Xs = 8'h00; start = done_start;
        tick();
        start = 1'b0;
        xs_vec.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; et_log2 = 4'd0; valid_in = 1'b0; Xs = 8'h00;
        repeat (3) tick();
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_k_out", k_out, 4'd0);
        chk("reset_bzs", pack_bzs(), 64'h0);
        rst_n = 1'b1;
        tick();

        // Full-length stream of all ones: saturates every lane.
        for (int i = 0; i < 256; i++) xs_vec.push_back(8'hFF);
        convert(4'd8, 8, 0, 1'b0, 1'b0, '1);

        // k=4: lane0 half ones, lane1 zero, lane2 all ones.
        for (int i = 0; i < 16; i++) xs_vec.push_back(((i % 2) == 0) ? 8'h05 : 8'h04);
        convert(4'd4, 4, 0, 1'b0, 1'b0, 64'h0000_0000_00FF_0080);

        // k=4 with ones only on invalid cycles.
        for (int i = 0; i < 16; i++) xs_vec.push_back(8'h00);
        convert(4'd4, 4, 1, 1'b0, 1'b0, 64'h0);

        // Clamp low: et_log2=0 behaves as k=1.
        xs_vec.push_back(8'h01);
        xs_vec.push_back(8'h00);
        convert(4'd0, 1, 0, 1'b0, 1'b0, 64'h80);

        // Clamp high: et_log2=15 behaves as k=8; every lane sees 128 ones.
        for (int i = 0; i < 256; i++) xs_vec.push_back(8'(i));
        convert(4'd15, 8, 0, 1'b0, 1'b0, 64'h8080_8080_8080_8080);

        // start pulsed mid-run and during done must be ignored.
        for (int i = 0; i < 8; i++) xs_vec.push_back((i < 3) ? 8'h03 : 8'h01);
        convert(4'd3, 3, 0, 1'b1, 1'b1, 64'h60FF);
        chk("idle_after_done_start", busy, 1'b0);

        // Reset mid-run aborts with no done and clears outputs.
        start = 1'b1; et_log2 = 4'd4; valid_in = 1'b0;
        tick();
        start = 1'b0; valid_in = 1'b1; Xs = 8'hFF;
        repeat (5) tick();
        chk("busy_mid_run", busy, 1'b1);
        rst_n = 1'b0;
        tick();
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_k_out", k_out, 4'd0);
        chk("abort_bzs", pack_bzs(), 64'h0);
        rst_n = 1'b1;
        repeat (20) tick();
        chk("idle_after_abort", busy, 1'b0);
        valid_in = 1'b0; Xs = 8'h00;
        tick();

        // Back-to-back k=2 conversions.
        xs_vec.push_back(8'h01); xs_vec.push_back(8'h01);
        xs_vec.push_back(8'h00); xs_vec.push_back(8'h00);
        convert(4'd2, 2, 0, 1'b0, 1'b0, 64'h80);
        for (int i = 0; i < 4; i++) xs_vec.push_back(8'h01);
        convert(4'd2, 2, 0, 1'b0, 1'b0, 64'hFF);

        repeat (5) tick();
        chk("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
